// File: rtl/program_loader.sv
// program_loader: boot-time writer for the processor's program memory.
// Accepts a framed byte stream (LEN_HI, LEN_LO, 4*N payload bytes, CHK)
// over a valid/ready handshake, assembles big-endian 32-bit words, writes
// them to consecutive word addresses starting at BASE_ADDRESS and verifies
// a trailing XOR checksum. The processor is held in reset until a frame
// has loaded cleanly.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic        start_i,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q,       state_d;
  logic [7:0]  len_hi_q,      len_hi_d;       // first length byte, held for LEN_LO
  logic [15:0] len_q,         len_d;          // N, words in this frame
  logic [7:0]  chk_q,         chk_d;          // running XOR of accepted frame bytes
  logic [17:0] byte_cnt_q,    byte_cnt_d;     // payload bytes accepted so far
  logic [23:0] word_q,        word_d;         // first three bytes of the word in flight
  logic [15:0] word_count_q,  word_count_d;
  logic        mem_write_q,   mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_q,    mem_data_d;

  logic        accept;
  logic [15:0] len_next;
  logic [17:0] payload_bytes;

  // The loader is ready only while a frame is being received.
  assign byte_ready_o  = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                         (state_q == S_PAYLOAD) || (state_q == S_CHECK);
  assign busy_o        = byte_ready_o;
  assign done_o        = (state_q == S_DONE);
  assign error_o       = (state_q == S_ERROR);
  assign cpu_hold_o    = (state_q != S_DONE);
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = mem_address_q;
  assign mem_data_o    = mem_data_q;
  assign word_count_o  = word_count_q;

  assign accept        = byte_valid_i && byte_ready_o;
  assign len_next      = {len_hi_q, byte_data_i};
  assign payload_bytes = {len_q, 2'b00};

  // Next-state, datapath updates and the registered write strobe.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned; an unassigned path in always_comb infers a latch.
    state_d       = state_q;
    len_hi_d      = len_hi_q;
    len_d         = len_q;
    chk_d         = chk_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    word_count_d  = word_count_q;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (AUTO_START || start_i) begin
          state_d      = S_LEN_HI;
          chk_d        = '0;
          byte_cnt_d   = '0;
          word_count_d = '0;
        end
      end

      S_LEN_HI: begin
        if (accept) begin
          len_hi_d = byte_data_i;
          chk_d    = chk_q ^ byte_data_i;
          state_d  = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (accept) begin
          len_d = len_next;
          chk_d = chk_q ^ byte_data_i;
          // Oversized frames are rejected before any write is issued.
          if ({16'd0, len_next} > MEMORY_DEPTH) begin
            state_d = S_ERROR;
          end else if (len_next == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          chk_d      = chk_q ^ byte_data_i;
          byte_cnt_d = byte_cnt_q + 18'd1;
          word_d     = {word_q[15:0], byte_data_i};
          // Fourth byte of a word: strobe it out on the following cycle.
          // word_count_q already counts every earlier word, so it is the
          // index of this one.
          if (byte_cnt_q[1:0] == 2'b11) begin
            mem_write_d   = 1'b1;
            mem_data_d    = {word_q, byte_data_i};
            mem_address_d = BASE_ADDRESS + {14'd0, word_count_q, 2'b00};
            word_count_d  = word_count_q + 16'd1;
          end
          if (byte_cnt_d == payload_bytes) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (accept) begin
          state_d = (byte_data_i == chk_q) ? S_DONE : S_ERROR;
        end
      end

      S_DONE, S_ERROR: begin
        // A reload starts from clean counters; memory already written stays.
        if (start_i) begin
          state_d      = S_LEN_HI;
          chk_d        = '0;
          byte_cnt_d   = '0;
          word_count_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also drops any pending write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_hi_q      <= '0;
      len_q         <= '0;
      chk_q         <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      word_count_q  <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, independent of statement order.
      state_q       <= state_d;
      len_hi_q      <= len_hi_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      word_count_q  <= word_count_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
    end
  end

endmodule
